seq_multiplier: RTL

Parametrised, iterative radix-2 shift-add multiplier. It replaces the single-cycle combinational 32x32 multiplier wherever area matters more than latency. It accepts one operand pair per transaction through a valid/ready handshake and returns the full-width product through a second valid/ready handshake. A per-transaction mode input selects signed or unsigned operation. A zero-operand shortcut returns the result early.

---
 rtl/seq_multiplier.sv | 86 ++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative radix-2 shift-add multiplier with valid/ready handshakes,
// signed/unsigned mode per transaction and a zero-operand shortcut.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   ain,
  input  logic [WIDTH-1:0]   bin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] dout,
  output logic               busy
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mc_q, mc_d, dout_q, dout_d, sum;
  logic [WIDTH-1:0]   mp_q, mp_d, mag_a, mag_b;
  logic               neg_q, neg_d;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q == BUSY;
  assign dout      = dout_q;
  // The most-negative operand negates to itself, which read unsigned is exactly its magnitude.
  assign mag_a = (is_signed & ain[WIDTH-1]) ? -ain : ain;
  assign mag_b = (is_signed & bin[WIDTH-1]) ? -bin : bin;
  assign sum   = acc_q + (mp_q[0] ? mc_q : '0);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mc_d    = mc_q;
    mp_d    = mp_q;
    neg_d   = neg_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: if (in_valid) begin
        neg_d = is_signed & (ain[WIDTH-1] ^ bin[WIDTH-1]);
        mc_d  = {{WIDTH{1'b0}}, mag_a};
        mp_d  = mag_b;
        acc_d = '0;
        cnt_d = '0;
        if (ain == '0 || bin == '0) begin
          dout_d  = '0;
          state_d = DONE;
        end else state_d = BUSY;
      end
      BUSY: begin
        acc_d = sum;
        mc_d  = mc_q << 1;
        mp_d  = mp_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          dout_d  = neg_q ? -sum : sum;
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mc_q    <= '0;
      mp_q    <= '0;
      neg_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mc_q    <= mc_d;
      mp_q    <= mp_d;
      neg_q   <= neg_d;
      dout_q  <= dout_d;
    end
  end
endmodule
